onchip_ram_pipelined: RTL and testbench
=======================================

# onchip_ram_pipelined

Parametrised Avalon-MM on-chip RAM slave, successor to the fixed 32-bit/40000-word single-port RAM. Adds configurable width and depth, a selectable 1- or 2-cycle pipelined read with `readdatavalid`, a `waitrequest` stall path, and a hardware clear engine that zero-fills the array after reset or on request. Sits on the Qsys interconnect as the Nios data/instruction RAM.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8.
- `DEPTH`, 40000: number of words.
- `ADDR_W`, 16: word-address width; must satisfy 2^ADDR_W >= DEPTH.
- `READ_LATENCY`, 1: 1 = array output unregistered; 2 = extra output register.
- `CLEAR_ON_RESET`, 1: 1 = run the clear sweep after reset release.
- `INIT_FILE`, "onchip_ram.hex": preload image; ignored when CLEAR_ON_RESET=1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  word address.
- `byteenable`  in  DATA_W/8  per-byte write enables.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  DATA_W  write data.
- `clken`  in  1  clock enable; 0 stalls the block.
- `freeze`  in  1  write-protect; accepted writes are dropped.
- `clear_req`  in  1  one-cycle pulse; starts a zero-fill sweep.
- `readdata`  out  DATA_W  read data, valid only with `readdatavalid`.
- `readdatavalid`  out  1  one pulse per accepted read.
- `waitrequest`  out  1  1 = request not accepted this cycle.
- `clear_busy`  out  1  1 while the sweep runs.

## Operation
- FSM states are IDLE and CLEAR. On reset the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR: a counter `clr_addr` runs 0..DEPTH-1 and writes 0 with all bytes enabled, one word per enabled cycle. After DEPTH-1 is written, the FSM goes to IDLE.
- In IDLE, a `clear_req` pulse sends the FSM to CLEAR with `clr_addr`=0. `clear_req` is ignored while in CLEAR.
- `waitrequest` = (state==CLEAR) | ~clken.
- Accept condition: `chipselect` & (`read`|`write`) & ~`waitrequest`.
- A write is accepted when the accept condition holds and `write`=1. Each byte lane is written where its `byteenable` bit is 1.
  - The write is dropped when `freeze`=1 or `address` >= DEPTH.
  - `read` and `write` both set: treat as a write only; no `readdatavalid`.
- A read is accepted when the accept condition holds, `read`=1 and `write`=0. It enters the READ_LATENCY-deep valid/data pipeline.
  - `address` >= DEPTH returns 0 and still asserts `readdatavalid`.
- A read issued in the cycle after a write to the same address returns the new data.
- `clken`=0 freezes the whole pipeline and the clear counter. Outputs hold their values; no `readdatavalid` pulse is lost or duplicated.
- Reset mid-clear or mid-read: the pipeline is flushed and in-flight reads are discarded. The sweep restarts from 0 when CLEAR_ON_RESET=1.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `clear_busy`=CLEAR_ON_RESET, `waitrequest`=CLEAR_ON_RESET|~clken.
- Read latency: a read accepted at edge N gives `readdata`/`readdatavalid` after edge N+READ_LATENCY (counting enabled edges only).
- Throughput: one access per enabled cycle. Back-to-back reads give back-to-back valid pulses.
- Sweep duration: exactly DEPTH enabled cycles. `clear_busy` falls together with `waitrequest` on the edge that ends CLEAR.
- The write takes effect at the accepting edge.
- Reads accepted in the last IDLE cycle before a `clear_req` still complete during CLEAR.

## Structure
- Package `onchip_ram_pkg` holds:
  - state enum `ram_state_t` {IDLE, CLEAR};
  - constants `LAT_UNREG`=1 and `LAT_REG`=2;
  - function `clog2` for the counter width.
- Sub-module `onchip_ram_core`: an inferred single-port, byte-enabled RAM with 1-cycle synchronous read, parameterised by DATA_W, DEPTH and INIT_FILE.
- The top level holds the FSM, the clear counter, the address mux (host vs `clr_addr`), the range check and the latency pipeline.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> `waitrequest`=1 for 16 cycles; afterwards reads of all 16 addresses return 0.
- Write 0xDEADBEEF to addr 3 with byteenable 0b0101, after a prior 0 fill -> read addr 3 returns 0x00AD00EF. With READ_LATENCY=2, `readdatavalid` comes 2 cycles after acceptance.
- Four back-to-back reads of addrs 0..3 holding 0x11,0x22,0x33,0x44, with `clken` dropped for 2 cycles mid-stream -> exactly four valid pulses, in order, none duplicated.
- `freeze`=1, write 0x12345678 to addr 5 -> accepted with `waitrequest`=0, but a later read of addr 5 returns its old value.
- Read at addr 20 with DEPTH=16 -> `readdatavalid` with `readdata`=0. Write at addr 20 -> no array change.
- `clear_req` after writing 0xA5A5A5A5 to addr 7, with `reset_n` pulsed low at sweep cycle 5 -> sweep restarts from 0 and takes 16 cycles; addr 7 reads 0.

Source files
------------

// File: rtl/onchip_ram_pkg.sv
// ---------------------------------------------------------------------------
// onchip_ram_pkg
// Shared types and helpers for the pipelined on-chip RAM slave.
//   ram_state_t : top-level FSM states (IDLE, CLEAR)
//   LAT_UNREG   : read latency with the array output used directly
//   LAT_REG     : read latency with an extra output register
//   clog2()     : ceiling log2, minimum 1, used to size address counters
// ---------------------------------------------------------------------------
package onchip_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_t;

    localparam int unsigned LAT_UNREG = 1;
    localparam int unsigned LAT_REG   = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/onchip_ram_if.sv
// ---------------------------------------------------------------------------
// onchip_ram_if
// Avalon-MM slave bus bundle for onchip_ram_pipelined.
//   address, byteenable, chipselect, read, write, writedata : host -> RAM
//   readdata, readdatavalid, waitrequest                    : RAM -> host
// Modports: master (interconnect side), slave (RAM side).
// ---------------------------------------------------------------------------
interface onchip_ram_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/onchip_ram_core.sv
// ---------------------------------------------------------------------------
// onchip_ram_core
// Inferred single-port byte-enabled RAM, synchronous read with 1-cycle
// latency (read-before-write on the same port).
//   clk   : clock
//   en    : clock enable; 0 holds the array and the read register
//   we    : write enable
//   be    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   q     : registered read data
// ---------------------------------------------------------------------------
module onchip_ram_core
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 40000,
    parameter              INIT_FILE = "onchip_ram.hex"
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [DATA_W/8-1:0]       be,
    input  logic [clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         q
);

    localparam int unsigned NB = DATA_W / 8;

    // The preload image is attached by the vendor memory-initialisation
    // flow; nothing in this file loads it.
    localparam init_file_unused = INIT_FILE;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// onchip_ram_pipelined
// Parametrised Avalon-MM on-chip RAM slave with 1- or 2-cycle pipelined
// read, waitrequest stall path and a hardware zero-fill sweep.
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : Avalon-MM slave bundle (onchip_ram_if.slave)
//   clken      : clock enable; 0 stalls the FSM, sweep and read pipeline
//   freeze     : write-protect; accepted writes are dropped
//   clear_req  : one-cycle pulse in IDLE starts a zero-fill sweep
//   clear_busy : high while the sweep runs
// ---------------------------------------------------------------------------
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 40000,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter              INIT_FILE      = "onchip_ram.hex"
) (
    input  logic             clk,
    input  logic             reset_n,
    onchip_ram_if.slave      bus,
    input  logic             clken,
    input  logic             freeze,
    input  logic             clear_req,
    output logic             clear_busy
);

    localparam int unsigned      CNT_W       = clog2(DEPTH);
    localparam int unsigned      NB          = DATA_W / 8;
    localparam logic [CNT_W-1:0] LAST_ADDR   = CNT_W'(DEPTH - 1);
    localparam ram_state_t       RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    ram_state_t       state_q, state_d;
    logic [CNT_W-1:0] clr_addr_q, clr_addr_d;

    logic              in_range;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;

    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [CNT_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    logic              vld1_q;
    logic              ok1_q;
    logic [DATA_W-1:0] data1;

    // -----------------------------------------------------------------------
    // FSM and clear counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
        end else if (clken) begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    assign clear_busy      = (state_q == CLEAR);
    assign bus.waitrequest = clear_busy | ~clken;

    // -----------------------------------------------------------------------
    // Request decode and range check
    // -----------------------------------------------------------------------
    assign in_range = (32'(bus.address) < DEPTH);
    assign accept   = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
    assign wr_acc   = accept & bus.write;
    assign rd_acc   = accept & bus.read & ~bus.write;

    // The sweep owns the array port while busy; host requests are stalled
    // by waitrequest then, so no arbitration is needed.
    assign ram_we    = clear_busy | (wr_acc & ~freeze & in_range);
    assign ram_be    = clear_busy ? '1 : bus.byteenable;
    assign ram_addr  = clear_busy ? clr_addr_q : bus.address[CNT_W-1:0];
    assign ram_wdata = clear_busy ? '0 : bus.writedata;

    onchip_ram_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk   (clk),
        .en    (clken),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // -----------------------------------------------------------------------
    // Read pipeline. Stage 1 tracks the array read; ok1_q masks the array
    // output so out-of-range and idle cycles present zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld1_q <= 1'b0;
            ok1_q  <= 1'b0;
        end else if (clken) begin
            vld1_q <= rd_acc;
            ok1_q  <= rd_acc & in_range;
        end
    end

    assign data1 = ok1_q ? ram_q : '0;

    if (READ_LATENCY == LAT_REG) begin : g_lat_reg
        logic              vld2_q;
        logic [DATA_W-1:0] data2_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld2_q  <= 1'b0;
                data2_q <= '0;
            end else if (clken) begin
                vld2_q  <= vld1_q;
                data2_q <= data1;
            end
        end

        assign bus.readdatavalid = vld2_q;
        assign bus.readdata      = data2_q;
    end else begin : g_lat_unreg
        assign bus.readdatavalid = vld1_q;
        assign bus.readdata      = data1;
    end

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// tb_onchip_ram_pipelined
// Self-checking bench for onchip_ram_pipelined with DEPTH=16, ADDR_W=5,
// READ_LATENCY=2 and CLEAR_ON_RESET=1.
// ---------------------------------------------------------------------------
module tb_onchip_ram_pipelined;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 5;

    typedef struct {
        logic              cs;
        logic              rd;
        logic              wr;
        logic              frz;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wd;
        logic              exp_vld;
        logic [31:0]       exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic freeze;
    logic clear_req;
    logic clear_busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    vec_t        vecs[$];
    logic [31:0] got[$];

    bit          cken_pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          rd_pat   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0]  addr_pat [10] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] burst_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    onchip_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_ram_pipelined #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .READ_LATENCY   (2),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("onchip_ram.hex")
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .clken      (clken),
        .freeze     (freeze),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        freeze         = 1'b0;
    endtask

    function automatic vec_t v_wr(input logic [4:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, input logic frz);
        vec_t v;
        v = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, frz: frz, addr: a, be: be, wd: wd,
              exp_vld: 1'b0, exp_data: 32'h0};
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [4:0] a, input logic [31:0] exp);
        vec_t v;
        v = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, frz: 1'b0, addr: a, be: 4'h0, wd: 32'h0,
              exp_vld: 1'b1, exp_data: exp};
        return v;
    endfunction

    // Counts cycles until waitrequest drops (bounded) and flags any
    // readdatavalid seen while the sweep is running.
    task automatic wait_sweep(input string name);
        int unsigned n  = 0;
        int unsigned nv = 0;
        while (bus.waitrequest && n < 100) begin
            if (bus.readdatavalid) nv++;
            @(negedge clk);
            n++;
        end
        check({name, "_cycles"}, 32'(n), 32'd16);
        check({name, "_no_valid"}, 32'(nv), 32'd0);
        check({name, "_busy_low"}, 32'(clear_busy), 32'd0);
    endtask

    // One access, then verify nothing appears after one edge and the
    // expected result appears after the second.
    task automatic do_op(input int unsigned idx, input vec_t v);
        @(negedge clk);
        bus.chipselect = v.cs;
        bus.read       = v.rd;
        bus.write      = v.wr;
        bus.address    = v.addr;
        bus.byteenable = v.be;
        bus.writedata  = v.wd;
        freeze         = v.frz;
        check($sformatf("vec%0d_waitrequest", idx), 32'(bus.waitrequest), 32'd0);
        @(negedge clk);
        drive_idle();
        check($sformatf("vec%0d_early_valid", idx), 32'(bus.readdatavalid), 32'd0);
        @(negedge clk);
        check($sformatf("vec%0d_valid", idx), 32'(bus.readdatavalid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            check($sformatf("vec%0d_data", idx), bus.readdata, v.exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit prev_en;

        reset_n   = 1'b0;
        clken     = 1'b1;
        clear_req = 1'b0;
        drive_idle();

        // ---------------- reset state and post-reset sweep ----------------
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 32'(bus.waitrequest), 32'd1);
        check("rst_clear_busy", 32'(clear_busy), 32'd1);
        check("rst_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        reset_n = 1'b1;
        wait_sweep("sweep_after_reset");

        // ---------------- table-driven accesses ----------------
        for (int unsigned a = 0; a < DEPTH; a++) begin
            vecs.push_back(v_rd(5'(a), 32'h0));
        end
        vecs.push_back(v_wr(5'd3, 4'b0101, 32'hDEADBEEF, 1'b0));
        vecs.push_back(v_rd(5'd3, 32'h00AD00EF));
        vecs.push_back(v_wr(5'd0, 4'hF, 32'h11, 1'b0));
        vecs.push_back(v_wr(5'd1, 4'hF, 32'h22, 1'b0));
        vecs.push_back(v_wr(5'd2, 4'hF, 32'h33, 1'b0));
        vecs.push_back(v_wr(5'd3, 4'hF, 32'h44, 1'b0));
        vecs.push_back(v_rd(5'd3, 32'h44));
        vecs.push_back(v_wr(5'd5, 4'hF, 32'h12345678, 1'b1));
        vecs.push_back(v_rd(5'd5, 32'h0));
        vecs.push_back(v_wr(5'd20, 4'hF, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(v_rd(5'd20, 32'h0));
        vecs.push_back(v_rd(5'd4, 32'h0));
        vecs.push_back('{cs: 1'b1, rd: 1'b1, wr: 1'b1, frz: 1'b0, addr: 5'd6, be: 4'hF,
                         wd: 32'h66, exp_vld: 1'b0, exp_data: 32'h0});
        vecs.push_back(v_rd(5'd6, 32'h66));
        vecs.push_back('{cs: 1'b0, rd: 1'b1, wr: 1'b0, frz: 1'b0, addr: 5'd3, be: 4'h0,
                         wd: 32'h0, exp_vld: 1'b0, exp_data: 32'h0});
        vecs.push_back(v_wr(5'd7, 4'hF, 32'hA5A5A5A5, 1'b0));
        vecs.push_back(v_rd(5'd7, 32'hA5A5A5A5));

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            do_op(i, vecs[i]);
        end

        // ---------------- back-to-back reads with a clken stall ----------------
        prev_en = 1'b0;
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            if (prev_en && bus.readdatavalid) got.push_back(bus.readdata);
            if (c == 3) begin
                check("stall_waitrequest", 32'(bus.waitrequest), 32'd1);
                check("stall_hold_valid", 32'(bus.readdatavalid), 32'd1);
                check("stall_hold_data", bus.readdata, 32'h11);
            end
            clken          = cken_pat[c];
            bus.chipselect = rd_pat[c];
            bus.read       = rd_pat[c];
            bus.address    = addr_pat[c];
            prev_en        = cken_pat[c];
        end
        @(negedge clk);
        if (prev_en && bus.readdatavalid) got.push_back(bus.readdata);
        clken = 1'b1;
        drive_idle();
        check("burst_pulse_count", 32'(got.size()), 32'd4);
        for (int unsigned k = 0; k < 4; k++) begin
            check($sformatf("burst_data%0d", k), (k < got.size()) ? got[k] : 32'hX, burst_exp[k]);
        end

        // ---------------- clear_req with in-flight read, reset mid-sweep ----------------
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 5'd1;
        clear_req      = 1'b1;
        @(negedge clk);
        drive_idle();
        clear_req = 1'b0;
        check("clr_busy", 32'(clear_busy), 32'd1);
        check("clr_waitrequest", 32'(bus.waitrequest), 32'd1);
        check("clr_read_early", 32'(bus.readdatavalid), 32'd0);
        @(negedge clk);
        check("clr_read_valid", 32'(bus.readdatavalid), 32'd1);
        check("clr_read_data", bus.readdata, 32'h22);
        repeat (4) @(negedge clk);
        check("clr_busy_cycle5", 32'(clear_busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midclr_rst_waitrequest", 32'(bus.waitrequest), 32'd1);
        check("midclr_rst_busy", 32'(clear_busy), 32'd1);
        reset_n = 1'b1;
        wait_sweep("sweep_after_midclear_reset");
        do_op(100, v_rd(5'd7, 32'h0));
        do_op(101, v_rd(5'd1, 32'h0));

        // ---------------- reset flushes an in-flight read ----------------
        do_op(102, v_wr(5'd2, 4'hF, 32'h33, 1'b0));
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 5'd2;
        @(negedge clk);
        drive_idle();
        reset_n = 1'b0;
        @(negedge clk);
        check("flush_rst_valid", 32'(bus.readdatavalid), 32'd0);
        reset_n = 1'b1;
        wait_sweep("sweep_after_flush_reset");
        do_op(103, v_rd(5'd2, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
